// File: rtl/vx_muldiv_arb_pkg.sv
// Shared constants and helpers for the muldiv request arbiter.
package vx_muldiv_arb_pkg;

  localparam int unsigned PERF_CNT_W = 32;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned req_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_muldiv_arb_rr.sv
// Round-robin core: eligibility mask, rr_ptr and one-hot grant.
// The search starts one past the last grant and wraps to index 0.
module vx_muldiv_arb_rr #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned REQ_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_valid,
  input  logic [NUM_REQS-1:0] credit_ok,
  input  logic                advance,
  output logic                grant_valid_c,
  output logic [REQ_BITS-1:0] grant_idx_c,
  output logic [NUM_REQS-1:0] grant_onehot_c
);

  logic [NUM_REQS-1:0] eligible_c;
  logic [REQ_BITS-1:0] rr_ptr;

  assign eligible_c = req_valid & credit_ok;

  // First eligible requester after rr_ptr, in circular order.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_REQS; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQS;
      if (!grant_valid_c && eligible_c[idx]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = REQ_BITS'(idx);
      end
    end
  end

  assign grant_onehot_c = grant_valid_c ? (NUM_REQS'(1) << grant_idx_c) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= REQ_BITS'(NUM_REQS - 1);
    end else if (advance) begin
      rr_ptr <= grant_idx_c;
    end
  end

endmodule

// File: rtl/vx_muldiv_arb.sv
// Arbitrates NUM_REQS requesters onto one muldiv unit with per-requester credits.
// Optional MULDIV_ARB_PERF_EN adds per-requester stall cycle counters.
module vx_muldiv_arb
  import vx_muldiv_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned REQ_DATAW   = 128,
  parameter int unsigned RSP_DATAW   = 64,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned REQ_BITS   = req_bits(NUM_REQS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          unit_valid,
  output logic [REQ_DATAW-1:0]          unit_data,
  output logic [REQ_BITS-1:0]           unit_sel,
  input  logic                          unit_ready,
  input  logic                          unit_rsp_valid,
  input  logic [REQ_BITS-1:0]           unit_rsp_sel,
  input  logic [RSP_DATAW-1:0]          unit_rsp_data,
  output logic                          unit_rsp_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [NUM_REQS*RSP_DATAW-1:0] rsp_data,
  input  logic [NUM_REQS-1:0]           rsp_ready
`ifdef MULDIV_ARB_PERF_EN
  ,
  output logic [NUM_REQS*PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0]     pending_cnt [NUM_REQS];
  logic [REQ_DATAW-1:0] req_arr_c   [NUM_REQS];
  logic [NUM_REQS-1:0]  credit_ok_c;
  logic [NUM_REQS-1:0]  inc_c;
  logic [NUM_REQS-1:0]  dec_c;
  logic                 grant_valid_c;
  logic [REQ_BITS-1:0]  grant_idx_c;
  logic [NUM_REQS-1:0]  grant_onehot_c;
  logic                 load_c;
  logic                 take_c;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_arr_c[i]   = req_data[i*REQ_DATAW +: REQ_DATAW];
      credit_ok_c[i] = pending_cnt[i] < CNT_W'(MAX_PENDING);
    end
  end

  vx_muldiv_arb_rr #(
    .NUM_REQS (NUM_REQS),
    .REQ_BITS (REQ_BITS)
  ) u_rr (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .credit_ok      (credit_ok_c),
    .advance        (take_c),
    .grant_valid_c  (grant_valid_c),
    .grant_idx_c    (grant_idx_c),
    .grant_onehot_c (grant_onehot_c)
  );

  // Output stage refills when empty or draining; nothing is accepted in reset.
  assign load_c    = !unit_valid || unit_ready;
  assign take_c    = reset && load_c && grant_valid_c;
  assign req_ready = take_c ? grant_onehot_c : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      unit_valid <= 1'b0;
    end else if (load_c) begin
      unit_valid <= grant_valid_c;
    end
  end

  always_ff @(posedge clk) begin
    if (take_c) begin
      unit_data <= req_arr_c[grant_idx_c];
      unit_sel  <= grant_idx_c;
    end
  end

  // Response demux: routed purely by the returned requester index.
  always_comb begin
    unit_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_valid[i] = unit_rsp_valid && (unit_rsp_sel == REQ_BITS'(i));
      if (unit_rsp_sel == REQ_BITS'(i)) begin
        unit_rsp_ready = rsp_ready[i];
      end
    end
  end

  assign rsp_data = {NUM_REQS{unit_rsp_data}};
  assign inc_c    = req_valid & req_ready;
  assign dec_c    = rsp_valid & rsp_ready;

  // Credit counters; a simultaneous issue and retire cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) pending_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (inc_c[i] && !dec_c[i]) begin
          pending_cnt[i] <= pending_cnt[i] + CNT_W'(1);
        end else if (dec_c[i] && !inc_c[i] && pending_cnt[i] != '0) begin
          pending_cnt[i] <= pending_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_chk
    a_rsp_no_credit: assert property (@(posedge clk) disable iff (!reset)
      !(rsp_valid[g] && pending_cnt[g] == '0));
  end

`ifdef MULDIV_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          perf_stall_cycles[i*PERF_CNT_W +: PERF_CNT_W] <=
            perf_stall_cycles[i*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_muldiv_arb.sv
// Directed bench for vx_muldiv_arb: vector table plus multi-cycle sequences.
module tb_vx_muldiv_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 16;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             unit_valid;
  logic [DW-1:0]    unit_data;
  logic [1:0]       unit_sel;
  logic             unit_ready;
  logic             unit_rsp_valid;
  logic [1:0]       unit_rsp_sel;
  logic [RW-1:0]    unit_rsp_data;
  logic             unit_rsp_ready;
  logic [NR-1:0]    rsp_valid;
  logic [NR*RW-1:0] rsp_data;
  logic [NR-1:0]    rsp_ready;
`ifdef MULDIV_ARB_PERF_EN
  logic [NR*32-1:0] perf_stall_cycles;
`endif

  vx_muldiv_arb #(
    .NUM_REQS    (NR),
    .REQ_DATAW   (DW),
    .RSP_DATAW   (RW),
    .MAX_PENDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .unit_valid     (unit_valid),
    .unit_data      (unit_data),
    .unit_sel       (unit_sel),
    .unit_ready     (unit_ready),
    .unit_rsp_valid (unit_rsp_valid),
    .unit_rsp_sel   (unit_rsp_sel),
    .unit_rsp_data  (unit_rsp_data),
    .unit_rsp_ready (unit_rsp_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready)
`ifdef MULDIV_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [7];
  int   order [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    req_valid      = '0;
    unit_ready     = 1'b0;
    unit_rsp_valid = 1'b0;
    unit_rsp_sel   = '0;
    unit_rsp_data  = '0;
    rsp_ready      = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_counts_zero(input string nm);
    chk(nm, 32'(dut.pending_cnt[0]), 0);
    chk(nm, 32'(dut.pending_cnt[1]), 0);
    chk(nm, 32'(dut.pending_cnt[2]), 0);
    chk(nm, 32'(dut.pending_cnt[3]), 0);
  endtask

  initial begin
    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    vecs[0] = '{4'b0001, 4'b0001, 2'd0, 16'hA000};
    vecs[1] = '{4'b0110, 4'b0010, 2'd1, 16'hA001};
    vecs[2] = '{4'b1000, 4'b1000, 2'd3, 16'hA003};
    vecs[3] = '{4'b1100, 4'b0100, 2'd2, 16'hA002};
    vecs[4] = '{4'b0000, 4'b0000, 2'd0, 16'h0000};
    vecs[5] = '{4'b1111, 4'b0001, 2'd0, 16'hA000};
    vecs[6] = '{4'b1010, 4'b0010, 2'd1, 16'hA001};
    order   = '{0, 1, 2, 3, 0, 1};

    // Reset state
    do_reset();
    chk("rst_unit_valid", 32'(unit_valid), 0);
    chk("rst_rr_ptr", 32'(dut.u_rr.rr_ptr), 3);
    chk_counts_zero("rst_pending");

    // Single-cycle grant table, each from a fresh reset (rr_ptr=3, search from 0)
    for (int v = 0; v < 7; v++) begin
      do_reset();
      req_valid  = vecs[v].req;
      unit_ready = 1'b1;
      #2 chk("tbl_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
      tick();
      req_valid = '0;
      #1 chk("tbl_unit_valid", 32'(unit_valid), 32'(vecs[v].exp_ready != 0));
      if (vecs[v].exp_ready != 0) begin
        chk("tbl_unit_sel", 32'(unit_sel), 32'(vecs[v].exp_sel));
        chk("tbl_unit_data", 32'(unit_data), 32'(vecs[v].exp_data));
        chk("tbl_pending", 32'(dut.pending_cnt[vecs[v].exp_sel]), 1);
      end
    end

    // Fairness with all four valid
    do_reset();
    req_valid  = 4'hF;
    unit_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2 chk("fair_ready", 32'(req_ready), 32'(1) << order[k]);
      tick();
      #1 chk("fair_sel", 32'(unit_sel), 32'(order[k]));
    end

    // Backpressure: held entry stays put for 5 cycles
    do_reset();
    req_valid  = 4'hF;
    unit_ready = 1'b0;
    #2 chk("bp_first_ready", 32'(req_ready), 32'b0001);
    tick();
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(unit_valid), 1);
      chk("bp_sel", 32'(unit_sel), 0);
      chk("bp_data", 32'(unit_data), 32'h0000A000);
      tick();
    end
    unit_ready = 1'b1;
    #2;
    chk("bp_release_sel", 32'(unit_sel), 0);
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    chk("bp_next_sel", 32'(unit_sel), 1);
    chk("bp_next_data", 32'(unit_data), 32'h0000A001);

    // Credit limit on requester 1
    do_reset();
    unit_ready = 1'b1;
    req_valid  = 4'b0010;
    #2 chk("cr_grant1", 32'(req_ready), 32'b0010);
    tick();
    #2 chk("cr_grant2", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0110;
    #2;
    chk("cr_full", 32'(dut.pending_cnt[1]), 2);
    chk("cr_skip", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0010;
    #2 chk("cr_block", 32'(req_ready), 0);
    unit_rsp_valid = 1'b1;
    unit_rsp_sel   = 2'd1;
    unit_rsp_data  = 16'h1234;
    rsp_ready      = 4'b0010;
    #1;
    chk("cr_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("cr_rsp_ready", 32'(unit_rsp_ready), 1);
    tick();
    unit_rsp_valid = 1'b0;
    rsp_ready      = '0;
    #2;
    chk("cr_after_rsp", 32'(dut.pending_cnt[1]), 1);
    chk("cr_reopen", 32'(req_ready), 32'b0010);
    // Issue and retire on requester 1 in the same cycle
    unit_rsp_valid = 1'b1;
    unit_rsp_sel   = 2'd1;
    rsp_ready      = 4'b0010;
    tick();
    unit_rsp_valid = 1'b0;
    rsp_ready      = '0;
    req_valid      = '0;
    #1 chk("incdec_hold", 32'(dut.pending_cnt[1]), 1);

    // Response routing to requester 3
    req_valid = 4'b1000;
    #2 chk("rt_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid      = '0;
    unit_rsp_valid = 1'b1;
    unit_rsp_sel   = 2'd3;
    unit_rsp_data  = 16'hDEAD;
    rsp_ready      = '0;
    #2;
    chk("rt_rsp_valid", 32'(rsp_valid), 32'b1000);
    chk("rt_unit_rsp_ready", 32'(unit_rsp_ready), 0);
    chk("rt_data_lane3", 32'(rsp_data[63:48]), 32'h0000DEAD);
    chk("rt_data_lane0", 32'(rsp_data[15:0]), 32'h0000DEAD);
    tick();
    chk("rt_hold_pending", 32'(dut.pending_cnt[3]), 1);
    rsp_ready = 4'b1000;
    #2 chk("rt_unit_rsp_ready_hi", 32'(unit_rsp_ready), 1);
    tick();
    unit_rsp_valid = 1'b0;
    rsp_ready      = '0;
    #1 chk("rt_pending_dec", 32'(dut.pending_cnt[3]), 0);

    // Reset in the middle of an operation
    unit_ready = 1'b0;
    req_valid  = 4'b0001;
    tick();
    chk("mr_pre_valid", 32'(unit_valid), 1);
    chk("mr_pre_pending", 32'(dut.pending_cnt[0]), 1);
    reset = 1'b0;
    #2 chk("mr_ready_in_reset", 32'(req_ready), 0);
    tick();
    chk("mr_unit_valid", 32'(unit_valid), 0);
    chk("mr_rr_ptr", 32'(dut.u_rr.rr_ptr), 3);
    chk_counts_zero("mr_pending");
`ifdef MULDIV_ARB_PERF_EN
    chk("mr_perf0", perf_stall_cycles[31:0], 0);
    chk("mr_perf1", perf_stall_cycles[63:32], 0);
    chk("mr_perf2", perf_stall_cycles[95:64], 0);
    chk("mr_perf3", perf_stall_cycles[127:96], 0);
`endif
    req_valid = '0;
    reset     = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_muldiv_arb.md
VX_MULDIV_ARB -- requirements
Module: VX_muldiv_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing one muldiv unit; legal range 2..16.
REQ-002 SHALL have parameter REQ_DATAW, default 128: request payload width, carrying op_type, operands and tag.
REQ-003 SHALL have parameter RSP_DATAW, default 64: response payload width.
REQ-004 SHALL have parameter MAX_PENDING, default 4: maximum in-flight operations per requester; legal range 1..15.
REQ-005 SHALL have the following ports, clock and reset first:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS x REQ_DATAW  per-requester request payload.
- req_ready  out  NUM_REQS  per-requester request accept.
- unit_valid  out  1  request to the shared unit.
- unit_data  out  REQ_DATAW  payload of the granted request.
- unit_sel  out  REQ_BITS  index of the granted requester.
- unit_ready  in  1  shared unit accepts.
- unit_rsp_valid  in  1  response from the unit.
- unit_rsp_sel  in  REQ_BITS  requester index returned with the response.
- unit_rsp_data  in  RSP_DATAW  response payload.
- unit_rsp_ready  out  1  response accept.
- rsp_valid  out  NUM_REQS  per-requester response valid.
- rsp_data  out  NUM_REQS x RSP_DATAW  response payload, the same value broadcast to every requester.
- rsp_ready  in  NUM_REQS  per-requester response accept.

Function
REQ-006 Eligibility: requester i is eligible when req_valid[i] is high and pending_cnt[i] < MAX_PENDING.
REQ-007 Arbitration SHALL be round-robin among eligible requesters.
- The search starts at rr_ptr+1 modulo NUM_REQS.
- After a grant, rr_ptr becomes the granted index.
- The search wraps from NUM_REQS-1 to 0.
REQ-008 The output stage SHALL be a single registered entry (unit_valid, unit_data, unit_sel).
- It loads when it is empty or unit_ready is high.
- Request latency is exactly 1 cycle from the req accept edge to unit_valid.
REQ-009 req_ready[i] SHALL be high only for the granted index, and only while the output stage can load.
- At most one req_ready bit is high per cycle (one-hot or zero).
REQ-010 unit_valid, unit_data and unit_sel SHALL hold stable while unit_valid is high and unit_ready is low.
REQ-011 pending_cnt[i] SHALL increment on the req_valid[i] and req_ready[i] handshake.
REQ-012 pending_cnt[i] SHALL decrement on the rsp_valid[i] and rsp_ready[i] handshake.
REQ-013 When an increment and a decrement hit the same requester in the same cycle, pending_cnt[i] SHALL stay unchanged.
REQ-014 The response path SHALL be combinational demux with zero latency.
- rsp_valid[i] = unit_rsp_valid and (unit_rsp_sel == i).
- unit_rsp_ready = rsp_ready[unit_rsp_sel].
REQ-015 Responses MAY arrive out of order across requesters; routing SHALL use unit_rsp_sel only.
REQ-016 A requester whose pending_cnt equals MAX_PENDING SHALL be skipped and SHALL NOT block the others.
REQ-017 A response for a requester whose pending_cnt is 0 is illegal.
- An assertion SHALL fire.
- The counter SHALL saturate at 0.

Reset
REQ-018 While reset is low at a clk edge, the following SHALL clear: unit_valid=0, rr_ptr=NUM_REQS-1, every pending_cnt=0.
REQ-019 During reset, req_ready SHALL be all-zero. Any request in flight mid-operation is discarded.
REQ-020 unit_data and unit_sel SHALL NOT be reset (datapath registers).
REQ-021 Responses arriving in the first cycle after reset deassertion are illegal (REQ-017).

Configuration
REQ-022 Macro MULDIV_ARB_PERF_EN, when defined, SHALL add output perf_stall_cycles (NUM_REQS x 32).
- Counter i increments each cycle in which req_valid[i] is high and req_ready[i] is low.
- The counter wraps at 2^32.
- It clears on reset.
REQ-023 Without MULDIV_ARB_PERF_EN, the port and its counters SHALL be absent and all other behaviour identical.

Structure
REQ-024 The shared package VX_gpu_pkg SHALL hold the REQ_BITS localparam (`UP(`CLOG2(NUM_REQS))) and the perf counter width constant.
REQ-025 One sub-module, VX_rr_arbiter_core, SHALL hold the eligibility mask, the rr_ptr register and the one-hot grant.
- Everything else (output stage, credit counters, response demux, perf counters) stays in VX_muldiv_arb.

Verification
REQ-026 Single request: req_valid=4'b0001, unit_ready=1.
- req_ready=4'b0001 in cycle 0.
- unit_valid=1 and unit_sel=0 in cycle 1.
- pending_cnt[0]=1.
REQ-027 Fairness: all four requesters valid continuously, unit_ready=1.
- Grant order 0,1,2,3,0,1.
- Each requester granted exactly once per 4 cycles.
REQ-028 Backpressure: unit_ready=0 for 5 cycles with unit_valid=1.
- unit_data and unit_sel held constant.
- req_ready=0.
- Only the held entry issues on release.
REQ-029 Credit limit: MAX_PENDING=2, requester 1 issues 2 requests with no response.
- Requester 1 is skipped and requester 2 is granted.
- After one response to sel=1, requester 1 becomes eligible again.
REQ-030 Response routing: unit_rsp_sel=3, data=0xDEAD, rsp_ready[3]=0.
- rsp_valid=4'b1000 and unit_rsp_ready=0.
- When rsp_ready[3]=1, the handshake completes and pending_cnt[3] decrements.
REQ-031 Mid-operation reset: reset low with unit_valid=1 and pending counts nonzero.
- Next cycle: unit_valid=0, all counts 0, rr_ptr=3.
- With MULDIV_ARB_PERF_EN, stall counters read 0.
